// File: rtl/sort_32x8b_loader.sv
// Input stage of the 32x8b bitonic sorter: packs a valid/ready byte stream into
// padded N-element frames and presents them on a registered valid/ready output.
module sort_32x8b_loader #(
  parameter int unsigned N   = 32,
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] PAD = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic [5:0]     out_count,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int unsigned IW = $clog2(N);

  logic [N*W-1:0] fill_q;
  logic [N*W-1:0] frame_c;
  logic [IW-1:0]  idx_q;
  logic           pend_q;
  logic [5:0]     pend_cnt_q;
  logic           accept_c;
  logic           last_slot_c;
  logic           complete_c;
  logic           slot_free_c;
  logic [5:0]     cnt_c;

  // Ready depends only on registers and reset so upstream never sees a loop.
  assign in_ready    = !rst && !pend_q;
  assign accept_c    = in_valid && in_ready;
  assign last_slot_c = (idx_q == IW'(N - 1));
  assign complete_c  = accept_c && (last_slot_c || in_last);
  assign slot_free_c = !out_valid || out_ready;
  assign cnt_c       = 6'(idx_q) + 6'd1;

  // Completed frame: filled slots, the completing beat at idx, PAD above it.
  always_comb begin
    frame_c = fill_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == idx_q) begin
        frame_c[W*i +: W] = in_data;
      end else if (IW'(i) > idx_q) begin
        frame_c[W*i +: W] = PAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_cnt_q <= '0;
      fill_q     <= '0;
    end else begin
      if (accept_c) begin
        if (complete_c) begin
          idx_q <= '0;
        end else begin
          idx_q                <= idx_q + IW'(1);
          fill_q[idx_q*W +: W] <= in_data;
        end
      end

      // Pending frame has priority; while pending no beat can be accepted.
      if (pend_q) begin
        if (out_ready) begin
          out_data  <= fill_q;
          out_count <= pend_cnt_q;
          pend_q    <= 1'b0;
        end
      end else if (complete_c) begin
        if (slot_free_c) begin
          out_data  <= frame_c;
          out_count <= cnt_c;
          out_valid <= 1'b1;
        end else begin
          fill_q     <= frame_c;
          pend_cnt_q <= cnt_c;
          pend_q     <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_32x8b_loader.sv
// Bench for sort_32x8b_loader: directed scenarios plus a random soak, both
// scored against a frame-queue model of the loader (PAD=00 and PAD=FF copies).
module tb_sort_32x8b_loader;

  localparam int unsigned N = 32;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready0, in_ready1;
  logic [N*W-1:0] out_data0, out_data1;
  logic [5:0]     out_count0, out_count1;
  logic           out_valid0, out_valid1;

  int errors = 0;
  int checks = 0;

  sort_32x8b_loader #(.N(N), .W(W), .PAD(8'h00)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_count(out_count0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  sort_32x8b_loader #(.N(N), .W(W), .PAD(8'hFF)) u_dut_ff (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_count(out_count1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: frames that completed but are not yet drained, oldest first.
  logic [N*W-1:0] exp_q[$];
  int             exp_cnt[$];
  logic [W-1:0]   part[$];
  bit             model_live = 1'b0;

  function automatic logic [N*W-1:0] with_pad(input logic [N*W-1:0] f, input int cnt,
                                              input logic [W-1:0] pad);
    logic [N*W-1:0] r;
    r = f;
    for (int i = cnt; i < N; i++) r[W*i +: W] = pad;
    return r;
  endfunction

  // Check state at the falling edge, then apply this cycle's handshakes to the model.
  always @(negedge clk) begin
    logic           ev, er;
    logic [N*W-1:0] f;
    if (rst) begin
      checks++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL rst_in_ready got %b/%b want 0", in_ready0, in_ready1);
      end
      exp_q.delete();
      exp_cnt.delete();
      part.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      ev = (exp_q.size() != 0);
      er = (exp_q.size() < 2);
      checks++;
      if (out_valid0 !== ev || out_valid1 !== ev) begin
        errors++;
        $display("FAIL mon_out_valid got %b/%b want %b", out_valid0, out_valid1, ev);
      end
      checks++;
      if (in_ready0 !== er || in_ready1 !== er) begin
        errors++;
        $display("FAIL mon_in_ready got %b/%b want %b", in_ready0, in_ready1, er);
      end
      if (ev) begin
        checks++;
        if (out_data0 !== exp_q[0] || out_count0 !== 6'(exp_cnt[0])) begin
          errors++;
          $display("FAIL mon_frame_pad00 got %h/%0d want %h/%0d", out_data0, out_count0,
                   exp_q[0], exp_cnt[0]);
        end
        checks++;
        if (out_data1 !== with_pad(exp_q[0], exp_cnt[0], 8'hFF) || out_count1 !== 6'(exp_cnt[0])) begin
          errors++;
          $display("FAIL mon_frame_padff got %h/%0d want %h/%0d", out_data1, out_count1,
                   with_pad(exp_q[0], exp_cnt[0], 8'hFF), exp_cnt[0]);
        end
      end
      if (ev && out_ready) begin
        exp_q.pop_front();
        exp_cnt.pop_front();
      end
      if (in_valid && er) begin
        part.push_back(in_data);
        if (part.size() == N || in_last) begin
          f = '0;
          foreach (part[i]) f[W*i +: W] = part[i];
          exp_q.push_back(f);
          exp_cnt.push_back(part.size());
          part.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== '0 || out_count0 !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d want v=0 d=0 c=0", out_valid0, out_data0, out_count0);
    end
    checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== '0 || out_count1 !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs_ff got v=%b d=%h c=%0d want v=0 d=0 c=0", out_valid1, out_data1, out_count1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready0);
    end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 8'(31 - i); in_last = 1'b0;
      checks++;
      if (in_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL full_in_ready beat %0d got %b want 1", i, in_ready0);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_count0 !== 6'd32 || out_data0[7:0] !== 8'h1F || out_data0[255:248] !== 8'h00) begin
      errors++;
      $display("FAIL full_frame got v=%b c=%0d b0=%h b31=%h want v=1 c=32 b0=1f b31=00",
               out_valid0, out_count0, out_data0[7:0], out_data0[255:248]);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL full_valid_pulse got %b want 0", out_valid0);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] vals[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = vals[i]; in_last = (i == 4);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_data0[39:0] !== 40'hA5A4A3A2A1 || out_data0[255:40] !== '0 || out_count0 !== 6'd5) begin
      errors++;
      $display("FAIL short_frame got d=%h c=%0d want a5a4a3a2a1 zero-padded c=5", out_data0, out_count0);
    end
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_data0[7:0] !== 8'h77 || out_data0[255:8] !== '0 || out_count0 !== 6'd1) begin
      errors++;
      $display("FAIL short_next_slot0 got d=%h c=%0d want 77 at slot 0 c=1", out_data0, out_count0);
    end
    tick();
  endtask

  task automatic test_single_beat();
    logic [N*W-1:0] want;
    want = {{31{8'hFF}}, 8'h3C};
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_data1 !== want || out_count1 !== 6'd1 || out_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL single_beat_ff got d=%h c=%0d want d=%h c=1", out_data1, out_count1, want);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] fa, fb;
    for (int i = 0; i < 32; i++) begin
      fa[W*i +: W] = 8'(i);
      fb[W*i +: W] = 8'(i + 32);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
      checks++;
      if (in_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL bp_in_ready beat %0d got %b want 1", i, in_ready0);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'($urandom);
      checks++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_data0 !== fa) begin
        errors++;
        $display("FAIL bp_hold got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", in_ready0, out_valid0, out_data0, fa);
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== fb || in_ready0 !== 1'b1 || out_count0 !== 6'd32) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b c=%0d d=%h want v=1 rdy=1 c=32 d=%h",
               out_valid0, in_ready0, out_count0, out_data0, fb);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%b want 0", out_valid0);
    end
  endtask

  task automatic test_drain_and_complete();
    logic [N*W-1:0] fb;
    for (int i = 0; i < 32; i++) fb[W*i +: W] = 8'(8'hC0 + i);
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_last = 1'b0;
      in_data = (i < 32) ? 8'(8'h80 + i) : 8'(8'hC0 + i - 32);
      out_ready = (i == 63);
      checks++;
      if (in_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL dc_in_ready beat %0d got %b want 1", i, in_ready0);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== fb || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL dc_swap got v=%b rdy=%b d=%h want v=1 rdy=1 d=%h", out_valid0, in_ready0, out_data0, fb);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL dc_drain got v=%b want 0", out_valid0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [N*W-1:0] want;
    want = {32{8'h55}};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hE0 + i); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || out_count0 !== 6'd0) begin
      errors++;
      $display("FAIL rmid_reset got v=%b c=%0d want v=0 c=0", out_valid0, out_count0);
    end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== want || out_count0 !== 6'd32 || out_data1 !== want) begin
      errors++;
      $display("FAIL rmid_frame got v=%b c=%0d d=%h want all 55 c=32", out_valid0, out_count0, out_data0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL random_final_drain got v=%b rdy=%b want v=0 rdy=1", out_valid0, in_ready0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_single_beat();
    test_backpressure();
    test_drain_and_complete();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
